// File: rtl/imem_loader.sv
// ============================================================================
// Module   : imem_loader
// Purpose  : Arbitrates the single-port instruction RAM between the CPU fetch
//            stage and a byte-serial program loader. In IDLE the CPU drives
//            the RAM port. A load request hands the port to the loader. The
//            loader packs four UART bytes big-endian into each word and writes
//            the words at consecutive addresses. It stops on HALT_WORD (which
//            is still written) or when the RAM is full, then returns the port.
// Ports    : i_clk, i_rst_n         clock, async active-low reset
//            i_load_start           one-cycle load request (IDLE only)
//            i_rx_data/valid,o_rx_ready  byte stream handshake
//            i_pc, i_fetch_en       CPU fetch request (byte address)
//            o_cpu_stall            loader owns the RAM port
//            o_ram_addr/din/we/en   RAM port (word address)
//            o_words_loaded         words written by current/last load
//            o_load_done            one-cycle pulse at end of load
//            o_overflow             sticky: RAM filled without HALT
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader #(
  parameter int                   RAM_WIDTH = 32,
  parameter int                   RAM_DEPTH = 2048,
  parameter logic [RAM_WIDTH-1:0] HALT_WORD = 32'hFFFFFFFF
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_load_start,
  input  logic [7:0]           i_rx_data,
  input  logic                 i_rx_valid,
  output logic                 o_rx_ready,
  input  logic [RAM_WIDTH-1:0] i_pc,
  input  logic                 i_fetch_en,
  output logic                 o_cpu_stall,
  output logic [RAM_WIDTH-1:0] o_ram_addr,
  output logic [RAM_WIDTH-1:0] o_ram_din,
  output logic                 o_ram_we,
  output logic                 o_ram_en,
  output logic [11:0]          o_words_loaded,
  output logic                 o_load_done,
  output logic                 o_overflow
);

  localparam logic [1:0]  c_IDLE  = 2'd0;
  localparam logic [1:0]  c_RECV  = 2'd1;
  localparam logic [1:0]  c_WRITE = 2'd2;
  localparam logic [1:0]  c_DONE  = 2'd3;
  localparam logic [11:0] c_LAST  = 12'(RAM_DEPTH - 1);

  logic [1:0]           r_state;
  logic [1:0]           r_byte_cnt;
  logic [11:0]          r_word_cnt;
  logic [RAM_WIDTH-1:0] r_word;
  logic                 r_overflow;
  logic                 w_accept;

  // The CPU addresses bytes; the RAM is word addressed, so the two low PC
  // bits never reach the RAM.
  logic w_pc_lsb_unused;
  assign w_pc_lsb_unused = ^i_pc[1:0];

  assign w_accept = (r_state == c_RECV) && i_rx_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= c_IDLE;
      r_byte_cnt <= 2'd0;
      r_word_cnt <= 12'd0;
      r_word     <= '0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (i_load_start) begin
            r_state    <= c_RECV;
            r_byte_cnt <= 2'd0;
            r_word_cnt <= 12'd0;
            r_word     <= '0;
            r_overflow <= 1'b0;
          end
        end
        c_RECV: begin
          if (w_accept) begin
            // First byte of a word ends up in the top byte (big-endian).
            r_word     <= {r_word[RAM_WIDTH-9:0], i_rx_data};
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              r_state <= c_WRITE;
            end
          end
        end
        c_WRITE: begin
          r_word_cnt <= r_word_cnt + 12'd1;
          // HALT wins over full, so a HALT in the last slot is not overflow.
          if (r_word == HALT_WORD) begin
            r_state <= c_DONE;
          end else if (r_word_cnt == c_LAST) begin
            r_state    <= c_DONE;
            r_overflow <= 1'b1;
          end else begin
            r_state <= c_RECV;
          end
        end
        c_DONE: begin
          r_state <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    o_ram_addr  = '0;
    o_ram_din   = '0;
    o_ram_we    = 1'b0;
    o_ram_en    = 1'b0;
    o_rx_ready  = 1'b0;
    o_load_done = 1'b0;
    o_cpu_stall = 1'b1;
    case (r_state)
      c_IDLE: begin
        // Fetch path is combinational so the CPU sees no extra latency.
        o_ram_addr  = {2'b00, i_pc[RAM_WIDTH-1:2]};
        o_ram_en    = i_fetch_en;
        o_cpu_stall = 1'b0;
      end
      c_RECV: begin
        o_rx_ready = 1'b1;
      end
      c_WRITE: begin
        o_ram_addr = RAM_WIDTH'(r_word_cnt);
        o_ram_din  = r_word;
        o_ram_we   = 1'b1;
        o_ram_en   = 1'b1;
      end
      c_DONE: begin
        o_load_done = 1'b1;
      end
      default: begin
        o_cpu_stall = 1'b1;
      end
    endcase
  end

  assign o_words_loaded = r_word_cnt;
  assign o_overflow     = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module   : tb_imem_loader
// Purpose  : Self-checking bench for imem_loader. Instance A uses the default
//            depth and is followed cycle by cycle by a transaction-level
//            model. Instance B uses a depth of 4 to reach the full-memory case.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;

  localparam logic [31:0] HALT = 32'hFFFFFFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;

  // Instance A (depth 2048)
  logic        a_start, a_valid, a_ready, a_fetch, a_stall, a_we, a_en, a_done, a_ovf;
  logic [7:0]  a_data;
  logic [31:0] a_pc, a_addr, a_din;
  logic [11:0] a_wl;
  // Instance B (depth 4)
  logic        b_start, b_valid, b_ready, b_fetch, b_stall, b_we, b_en, b_done, b_ovf;
  logic [7:0]  b_data;
  logic [31:0] b_pc, b_addr, b_din;
  logic [11:0] b_wl;

  imem_loader u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_load_start(a_start),
    .i_rx_data(a_data), .i_rx_valid(a_valid), .o_rx_ready(a_ready),
    .i_pc(a_pc), .i_fetch_en(a_fetch), .o_cpu_stall(a_stall),
    .o_ram_addr(a_addr), .o_ram_din(a_din), .o_ram_we(a_we), .o_ram_en(a_en),
    .o_words_loaded(a_wl), .o_load_done(a_done), .o_overflow(a_ovf)
  );

  imem_loader #(.RAM_DEPTH(4)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_load_start(b_start),
    .i_rx_data(b_data), .i_rx_valid(b_valid), .o_rx_ready(b_ready),
    .i_pc(b_pc), .i_fetch_en(b_fetch), .o_cpu_stall(b_stall),
    .o_ram_addr(b_addr), .o_ram_din(b_din), .o_ram_we(b_we), .o_ram_en(b_en),
    .o_words_loaded(b_wl), .o_load_done(b_done), .o_overflow(b_ovf)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model of instance A ----------------
  // Busy from the accepted start until the done cycle has passed; a word is
  // due for writing on the cycle after its fourth byte; the done pulse
  // follows the terminating write.
  bit          m_busy, m_wr, m_done, m_ovf;
  logic [31:0] m_word;
  int          m_nb, m_addr, m_loaded;

  initial begin
    m_busy = 0; m_wr = 0; m_done = 0; m_ovf = 0; m_word = 0;
    m_nb = 0; m_addr = 0; m_loaded = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_busy = 0; m_wr = 0; m_done = 0; m_ovf = 0;
        m_nb = 0; m_addr = 0; m_loaded = 0;
      end else if (m_done) begin
        m_done = 0;
        m_busy = 0;
      end else if (m_wr) begin
        m_wr = 0;
        m_loaded++;
        if (m_word == HALT) m_done = 1;
        else if (m_addr == 2047) begin m_done = 1; m_ovf = 1; end
        m_addr++;
      end else if (m_busy) begin
        if (a_valid) begin
          m_word = {m_word[23:0], a_data};
          m_nb++;
          if (m_nb == 4) begin m_nb = 0; m_wr = 1; end
        end
      end else if (a_start) begin
        m_busy = 1; m_addr = 0; m_loaded = 0; m_ovf = 0; m_nb = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("stall", {31'd0, a_stall}, {31'd0, m_busy});
        chk("rx_ready", {31'd0, a_ready}, {31'd0, m_busy && !m_wr && !m_done});
        chk("load_done", {31'd0, a_done}, {31'd0, m_done});
        chk("ram_we", {31'd0, a_we}, {31'd0, m_wr});
        chk("ram_en", {31'd0, a_en}, {31'd0, m_busy ? m_wr : a_fetch});
        chk("words_loaded", {20'd0, a_wl}, 32'(m_loaded));
        chk("overflow", {31'd0, a_ovf}, {31'd0, m_ovf});
        if (m_wr) begin
          chk("wr_addr", a_addr, 32'(m_addr));
          chk("wr_data", a_din, m_word);
        end else if (!m_busy && a_fetch) begin
          chk("fetch_addr", a_addr, {2'b00, a_pc[31:2]});
        end
      end
    end
  end

  // ---------------- write/pulse monitors for literal checks ----------------
  logic [31:0] mem_a [0:15];
  logic [31:0] mem_b [0:15];
  int wcnt_a = 0, wcnt_b = 0, dn_a = 0, dn_b = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (a_we) begin wcnt_a++; if (a_addr < 32'd16) mem_a[a_addr[3:0]] = a_din; end
      if (b_we) begin wcnt_b++; if (b_addr < 32'd16) mem_b[b_addr[3:0]] = b_din; end
      if (a_done) dn_a++;
      if (b_done) dn_b++;
    end
  end

  // ---------------- stimulus helpers (inputs change 2 units after posedge) ----
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start(input bit use_b);
    if (use_b) b_start = 1'b1; else a_start = 1'b1;
    tick();
    a_start = 1'b0;
    b_start = 1'b0;
  endtask

  task automatic send(input bit use_b, input logic [7:0] b, input int gap);
    bit acc;
    int n;
    repeat (gap) tick();
    if (use_b) begin b_valid = 1'b1; b_data = b; end
    else       begin a_valid = 1'b1; a_data = b; end
    acc = 0;
    n   = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = use_b ? b_ready : a_ready;
      tick();
      n++;
    end
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout: byte %h not accepted within 50 cycles", b);
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic send_word(input bit use_b, input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) send(use_b, w[31-8*i -: 8], gap);
  endtask

  initial begin
    a_start = 0; a_valid = 0; a_data = 0; a_pc = 32'h10; a_fetch = 1;
    b_start = 0; b_valid = 0; b_data = 0; b_pc = 32'h0;  b_fetch = 0;

    // Reset values
    #12;
    chk("rst_addr", a_addr, 32'd4);
    chk("rst_en", {31'd0, a_en}, 32'd1);
    chk("rst_we", {31'd0, a_we}, 32'd0);
    chk("rst_stall", {31'd0, a_stall}, 32'd0);
    chk("rst_ready", {31'd0, a_ready}, 32'd0);
    chk("rst_wl", {20'd0, a_wl}, 32'd0);
    chk("rst_done", {31'd0, a_done}, 32'd0);
    chk("rst_ovf", {31'd0, a_ovf}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic load with gaps between bytes
    start(0);
    send_word(0, 32'h20080005, 0);
    send_word(0, 32'h00000000, 2);
    send_word(0, HALT, 1);
    repeat (4) tick();
    chk("t1_mem0", mem_a[0], 32'h20080005);
    chk("t1_mem1", mem_a[1], 32'h00000000);
    chk("t1_mem2", mem_a[2], HALT);
    chk("t1_wl", {20'd0, a_wl}, 32'd3);
    chk("t1_writes", 32'(wcnt_a), 32'd3);
    chk("t1_done_pulses", 32'(dn_a), 32'd1);
    chk("t1_ovf", {31'd0, a_ovf}, 32'd0);
    chk("t1_stall", {31'd0, a_stall}, 32'd0);
    a_pc = 32'h40;
    #1;
    chk("t1_fetch_addr", a_addr, 32'h10);
    chk("t1_fetch_en", {31'd0, a_en}, 32'd1);

    // Start pulse during RECV is ignored
    start(0);
    send(0, 8'h11, 0);
    send(0, 8'h22, 0);
    start(0);
    send(0, 8'h33, 0);
    send(0, 8'h44, 0);
    send_word(0, HALT, 0);
    repeat (4) tick();
    chk("t2_mem0", mem_a[0], 32'h11223344);
    chk("t2_mem1", mem_a[1], HALT);
    chk("t2_wl", {20'd0, a_wl}, 32'd2);
    chk("t2_writes", 32'(wcnt_a), 32'd5);
    chk("t2_done_pulses", 32'(dn_a), 32'd2);

    // Reset after six bytes aborts the load
    start(0);
    send_word(0, 32'hAABBCCDD, 0);
    send(0, 8'h01, 0);
    send(0, 8'h02, 0);
    rst_n = 1'b0;
    #1;
    chk("t3_rst_stall", {31'd0, a_stall}, 32'd0);
    chk("t3_rst_wl", {20'd0, a_wl}, 32'd0);
    chk("t3_rst_ready", {31'd0, a_ready}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t3_writes_before", 32'(wcnt_a), 32'd6);
    start(0);
    send_word(0, 32'h12345678, 0);
    send_word(0, HALT, 0);
    repeat (4) tick();
    chk("t3_mem0", mem_a[0], 32'h12345678);
    chk("t3_mem1", mem_a[1], HALT);
    chk("t3_wl", {20'd0, a_wl}, 32'd2);
    chk("t3_writes", 32'(wcnt_a), 32'd8);
    chk("t3_done_pulses", 32'(dn_a), 32'd3);

    // Depth 4: fill without HALT -> overflow
    start(1);
    send_word(1, 32'h01020304, 0);
    send_word(1, 32'h05060708, 1);
    send_word(1, 32'h090A0B0C, 0);
    send_word(1, 32'h0D0E0F10, 0);
    repeat (4) tick();
    chk("t4_mem0", mem_b[0], 32'h01020304);
    chk("t4_mem1", mem_b[1], 32'h05060708);
    chk("t4_mem2", mem_b[2], 32'h090A0B0C);
    chk("t4_mem3", mem_b[3], 32'h0D0E0F10);
    chk("t4_writes", 32'(wcnt_b), 32'd4);
    chk("t4_ovf", {31'd0, b_ovf}, 32'd1);
    chk("t4_wl", {20'd0, b_wl}, 32'd4);
    chk("t4_done_pulses", 32'(dn_b), 32'd1);
    chk("t4_stall", {31'd0, b_stall}, 32'd0);

    // Next start clears overflow; HALT in the last slot is not overflow
    start(1);
    chk("t5_ovf_cleared", {31'd0, b_ovf}, 32'd0);
    send_word(1, 32'hCAFEF00D, 0);
    send_word(1, 32'h00000001, 0);
    send_word(1, 32'h00000002, 0);
    send_word(1, HALT, 0);
    repeat (4) tick();
    chk("t5_mem0", mem_b[0], 32'hCAFEF00D);
    chk("t5_mem3", mem_b[3], HALT);
    chk("t5_ovf", {31'd0, b_ovf}, 32'd0);
    chk("t5_wl", {20'd0, b_wl}, 32'd4);
    chk("t5_writes", 32'(wcnt_b), 32'd8);
    chk("t5_done_pulses", 32'(dn_b), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
